prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_pkg.sv | 16 +
 rtl/prod_accum_sat16.sv | 34 +++
 rtl/prod_accum.sv | 156 +++++++++++++++
 tb/tb_prod_accum.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/prod_pkg.sv
// prod_pkg -- shared definitions for the product accumulator.
// Holds the default accumulator and block-length widths, the product width
// and the controller state encoding used by prod_accum.
package prod_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 4;
  localparam int PROD_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum_sat16.sv
// sat16 -- combinational clamp of a signed W-bit value to the signed 16-bit range.
// Ports:
//   acc : input,  W bits, signed value to clamp (W must be at least 17)
//   sat : output, 16 bits, clamped value
//   ovf : output, 1 bit, high when a clamp was applied
module sat16 #(
  parameter int W = 24
) (
  input  logic [W-1:0] acc,
  output logic [15:0]  sat,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_V = W'(32767);
  localparam logic [W-1:0] MIN_V = W'(-32768);

  logic too_big;
  logic too_small;

  assign too_big   = $signed(acc) > $signed(MAX_V);
  assign too_small = $signed(acc) < $signed(MIN_V);

  always_comb begin
    sat = acc[15:0];
    if (too_big) begin
      sat = 16'h7FFF;
    end else if (too_small) begin
      sat = 16'h8000;
    end
  end

  assign ovf = too_big | too_small;

endmodule

// File: rtl/prod_accum.sv
// prod_accum -- accumulates a block of signed 16-bit products and returns the
// block sum plus a 16-bit saturated copy through a valid/ready handshake.
// Ports:
//   clk       : input,  clock, rising edge
//   rst       : input,  asynchronous active-low reset
//   prod      : input,  16 bits, signed product
//   in_valid  : input,  prod valid
//   in_ready  : output, block can accept prod (IDLE/ACC, and out of reset)
//   len       : input,  LEN_W bits, products per block (0 means 2^LEN_W),
//               sampled only on the first accept of a block
//   acc_out   : output, ACC_W bits, signed block sum
//   sat_out   : output, 16 bits, acc_out clamped to the signed 16-bit range
//   ovf       : output, sat_out was clamped
//   out_valid : output, result valid (DONE)
//   out_ready : input,  downstream takes the result
module prod_accum
  import prod_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN_W-1:0] len,
  output logic [ACC_W-1:0] acc_out,
  output logic [15:0]      sat_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  // One extra bit so a full 2^LEN_W block length is representable.
  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << LEN_W;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [15:0]      sat_out_q, sat_out_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             finish;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] len_eff;
  logic [15:0]      sat_next;
  logic             ovf_next;

  // in_ready is gated by rst directly so it drops as soon as reset asserts.
  assign in_ready = rst && (state_q != DONE);
  assign accept   = in_valid && in_ready;
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  assign len_eff  = (len == '0) ? CNT_FULL : {1'b0, len};

  // Candidate accumulator value for an accept this cycle: the first product
  // of a block replaces the old sum instead of adding to it.
  assign acc_sum = (state_q == IDLE) ? prod_ext : (acc_q + prod_ext);

  sat16 #(.W(ACC_W)) u_sat (
    .acc (acc_sum),
    .sat (sat_next),
    .ovf (ovf_next)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    len_d       = len_q;
    acc_out_d   = acc_out_q;
    sat_out_d   = sat_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    finish      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = acc_sum;
          len_d   = len_eff;
          count_d = CNT_ONE;
          if (len_eff == CNT_ONE) begin
            finish = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept) begin
          acc_d   = acc_sum;
          count_d = count_q + CNT_ONE;
          if ((count_q + CNT_ONE) == len_q) begin
            finish = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Result registers load only when a block completes, so they stay put
    // for the whole DONE phase regardless of out_ready.
    if (finish) begin
      state_d     = DONE;
      out_valid_d = 1'b1;
      acc_out_d   = acc_sum;
      sat_out_d   = sat_next;
      ovf_d       = ovf_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
      acc_out_q   <= '0;
      sat_out_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      len_q       <= len_d;
      acc_out_q   <= acc_out_d;
      sat_out_q   <= sat_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign sat_out   = sat_out_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum -- self-checking bench for prod_accum: directed blocks for the
// listed corner cases plus randomized blocks scored against a plain
// arithmetic model of the block sum and 16-bit clamp.
module tb_prod_accum;

  localparam int ACC_W = 24;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      prod;
  logic             in_valid;
  logic             in_ready;
  logic [LEN_W-1:0] len;
  logic [ACC_W-1:0] acc_out;
  logic [15:0]      sat_out;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  int errs   = 0;
  int checks = 0;
  int pq[$];

  always #5 clk = ~clk;

  prod_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .prod      (prod),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .len       (len),
    .acc_out   (acc_out),
    .sat_out   (sat_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input longint sum);
    longint exp_sat;
    longint exp_ovf;
    exp_sat = sum;
    exp_ovf = 0;
    if (sum > 32767) begin
      exp_sat = 32767;
      exp_ovf = 1;
    end else if (sum < -32768) begin
      exp_sat = -32768;
      exp_ovf = 1;
    end
    check({tag, ".acc_out"}, longint'($signed(acc_out)), sum);
    check({tag, ".sat_out"}, longint'($signed(sat_out)), exp_sat);
    check({tag, ".ovf"}, longint'(ovf), exp_ovf);
  endtask

  // Feeds the products in pq as one block. blen is the value on the len
  // port (0 = 16 products). gap idle cycles precede every product but the
  // first; stall extra DONE cycles hold out_ready low. rst_after > 0 pulses
  // reset after that many accepts instead of finishing the block.
  task automatic run_block(input string tag, input int blen, input int gap,
                           input int stall, input int rst_after);
    int     n;
    int     tmp;
    longint sum;
    n   = (blen == 0) ? 16 : blen;
    sum = 0;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          prod     = 16'($urandom);
          @(negedge clk);
          check({tag, ".gap_out_valid"}, longint'(out_valid), 0);
          check({tag, ".gap_in_ready"}, longint'(in_ready), 1);
        end
      end
      tmp      = pq[i];
      prod     = tmp[15:0];
      in_valid = 1'b1;
      // len only matters on the first accept; scramble it afterwards
      len      = (i == 0) ? LEN_W'(blen) : LEN_W'($urandom);
      check({tag, ".in_ready"}, longint'(in_ready), 1);
      check({tag, ".pre_out_valid"}, longint'(out_valid), 0);
      @(negedge clk);
      in_valid = 1'b0;
      sum += longint'(pq[i]);
      if (rst_after == i + 1) begin
        rst = 1'b0;
        #1;
        check({tag, ".rst_out_valid"}, longint'(out_valid), 0);
        check({tag, ".rst_acc_out"}, longint'(acc_out), 0);
        check({tag, ".rst_sat_out"}, longint'(sat_out), 0);
        check({tag, ".rst_ovf"}, longint'(ovf), 0);
        check({tag, ".rst_in_ready"}, longint'(in_ready), 0);
        @(negedge clk);
        check({tag, ".rst_hold_valid"}, longint'(out_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        check({tag, ".post_rst_out_valid"}, longint'(out_valid), 0);
        $display("block %s: reset after %0d accepts", tag, rst_after);
        return;
      end
    end
    // One cycle after the last accept the result must be presented.
    check({tag, ".out_valid"}, longint'(out_valid), 1);
    check({tag, ".done_in_ready"}, longint'(in_ready), 0);
    check_outputs(tag, sum);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, ".stall_out_valid"}, longint'(out_valid), 1);
      check({tag, ".stall_in_ready"}, longint'(in_ready), 0);
      check_outputs({tag, ".stall"}, sum);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".xfer_out_valid"}, longint'(out_valid), 0);
    check({tag, ".xfer_in_ready"}, longint'(in_ready), 1);
    $display("block %s: len=%0d n=%0d sum=%0d acc_out=%0d sat_out=%0d ovf=%0d",
             tag, blen, n, sum, $signed(acc_out), $signed(sat_out), ovf);
  endtask

  initial begin
    int a;
    int b;
    int rl;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    len       = '0;
    prod      = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset.out_valid", longint'(out_valid), 0);
    check("reset.acc_out", longint'(acc_out), 0);
    check("reset.sat_out", longint'(sat_out), 0);
    check("reset.ovf", longint'(ovf), 0);
    check("reset.in_ready", longint'(in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle.in_ready", longint'(in_ready), 1);

    pq = '{1, 2, 6, 12, 20, 30};
    run_block("len6", 6, 0, 0, 0);

    pq = '{-8, -18};
    run_block("neg", 2, 0, 0, 0);

    pq.delete();
    for (int i = 0; i < 16; i++) pq.push_back(16384);
    run_block("sat16", 0, 0, 0, 0);

    pq = '{-200, -32700};
    run_block("satneg", 2, 0, 0, 0);

    pq = '{100, -3};
    run_block("stall", 2, 0, 3, 0);

    pq = '{7, 7, 7, 7, 7, 7};
    run_block("midrst", 6, 0, 0, 3);

    pq = '{5};
    run_block("after_rst", 1, 0, 0, 0);

    pq = '{4, 4, 4};
    run_block("gaps", 3, 2, 0, 0);

    for (int k = 0; k < 20; k++) begin
      pq.delete();
      rl = $urandom_range(0, 15);
      for (int i = 0; i < ((rl == 0) ? 16 : rl); i++) begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
        pq.push_back(a * b);
      end
      run_block($sformatf("rand%0d", k), rl, $urandom_range(0, 2),
                $urandom_range(0, 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
